// File: rtl/keynote_pkg.sv
// Shared types and constants for the polyphonic scan-code voice tracker.
// Note table covers home row (0-11), top row (12-23) and shift/bottom row (24-35).
package keynote_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBreak,
        StExt,
        StExtBrk
    } parse_state_e;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam int unsigned NUM_NOTES = 36;
    localparam int unsigned BASE_W = 17;

    localparam logic [BASE_W-1:0] BASE_PERIOD [0:NUM_NOTES-1] = '{
        17'd22727, 17'd21452, 17'd20248, 17'd19111, 17'd18039, 17'd17026,
        17'd16070, 17'd15169, 17'd14317, 17'd13514, 17'd12755, 17'd12039,
        17'd23393, 17'd22080, 17'd20841, 17'd19671, 17'd18567, 17'd17525,
        17'd16541, 17'd15613, 17'd14737, 17'd13910, 17'd13129, 17'd12392,
        17'd11697, 17'd11040, 17'd10420, 17'd9836,  17'd9284,  17'd8762,
        17'd8271,  17'd7806,  17'd7368,  17'd6955,  17'd6564,  17'd6196
    };

    // Out-of-range note indices read as silence rather than indexing past the table.
    function automatic logic [BASE_W-1:0] base_period(logic [5:0] note);
        return (32'(note) < NUM_NOTES) ? BASE_PERIOD[note] : '0;
    endfunction

endpackage

// File: rtl/keynote_voice_tracker_if.sv
// Byte-stream and per-voice output bundle between the PS/2 receiver, tracker and tone counters.
interface keynote_voice_tracker_if #(
    parameter int unsigned NUM_VOICES = 2,
    parameter int unsigned PERIOD_W   = 17,
    parameter int unsigned OCT_W      = 2
);
    logic                           scan_valid;
    logic [7:0]                     scan_code;
    logic                           oct_up;
    logic                           oct_dn;
    logic [NUM_VOICES-1:0]          voice_active;
    logic [NUM_VOICES*PERIOD_W-1:0] voice_period;
    logic [OCT_W-1:0]               octave;
    logic                           drop;

    modport master (
        output scan_valid, scan_code, oct_up, oct_dn,
        input  voice_active, voice_period, octave, drop
    );

    modport slave (
        input  scan_valid, scan_code, oct_up, oct_dn,
        output voice_active, voice_period, octave, drop
    );

endinterface

// File: rtl/keynote_map.sv
// Combinational scan code to note index lookup; hit=0 for keys with no note.
module keynote_map (
    input  logic [7:0] code,
    output logic       hit,
    output logic [5:0] note_idx
);

    always_comb begin
        hit      = 1'b1;
        note_idx = '0;
        case (code)
            8'h1C: note_idx = 6'd0;
            8'h1B: note_idx = 6'd1;
            8'h23: note_idx = 6'd2;
            8'h2B: note_idx = 6'd3;
            8'h34: note_idx = 6'd4;
            8'h33: note_idx = 6'd5;
            8'h3B: note_idx = 6'd6;
            8'h42: note_idx = 6'd7;
            8'h4B: note_idx = 6'd8;
            8'h4C: note_idx = 6'd9;
            8'h52: note_idx = 6'd10;
            8'h5A: note_idx = 6'd11;
            8'h15: note_idx = 6'd12;
            8'h1D: note_idx = 6'd13;
            8'h24: note_idx = 6'd14;
            8'h2D: note_idx = 6'd15;
            8'h2C: note_idx = 6'd16;
            8'h35: note_idx = 6'd17;
            8'h3C: note_idx = 6'd18;
            8'h43: note_idx = 6'd19;
            8'h44: note_idx = 6'd20;
            8'h4D: note_idx = 6'd21;
            8'h54: note_idx = 6'd22;
            8'h5B: note_idx = 6'd23;
            8'h59: note_idx = 6'd24;
            8'h1A: note_idx = 6'd25;
            8'h22: note_idx = 6'd26;
            8'h21: note_idx = 6'd27;
            8'h2A: note_idx = 6'd28;
            8'h32: note_idx = 6'd29;
            8'h31: note_idx = 6'd30;
            8'h3A: note_idx = 6'd31;
            8'h41: note_idx = 6'd32;
            8'h49: note_idx = 6'd33;
            8'h4A: note_idx = 6'd34;
            8'h12: note_idx = 6'd35;
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/keynote_voice_tracker.sv
// Polyphonic PS/2 key tracker: parses make/break/extended prefixes, allocates held keys to
// voices and emits registered per-voice half-period counts scaled by a saturating octave.
module keynote_voice_tracker
    import keynote_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 2,
    parameter int unsigned PERIOD_W   = 17,
    parameter int unsigned OCT_MAX    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    keynote_voice_tracker_if.slave  bus
);

    localparam int unsigned OCT_W = (OCT_MAX > 0) ? $clog2(OCT_MAX + 1) : 1;

    parse_state_e                   state;
    logic                           map_hit;
    logic [5:0]                     map_note;
    logic                           make_ev;
    logic                           break_ev;
    logic [NUM_VOICES-1:0]          held;
    logic [NUM_VOICES-1:0]          alloc;
    logic [NUM_VOICES-1:0]          active_q;
    logic [7:0]                     key_q [NUM_VOICES];
    logic [5:0]                     note_q [NUM_VOICES];
    logic [OCT_W-1:0]               octave_q;
    logic                           drop_q;
    logic [NUM_VOICES-1:0]          active_out_q;
    logic [NUM_VOICES*PERIOD_W-1:0] period_out_q;

    keynote_map u_map (
        .code     (bus.scan_code),
        .hit      (map_hit),
        .note_idx (map_note)
    );

    // Prefix bytes never generate events; only a completing byte does.
    always_comb begin
        make_ev  = 1'b0;
        break_ev = 1'b0;
        if (bus.scan_valid && bus.scan_code != SC_BREAK && bus.scan_code != SC_EXT) begin
            if (state == StIdle) begin
                make_ev = map_hit;
            end else if (state == StBreak) begin
                break_ev = map_hit;
            end
        end
    end

    always_comb begin
        logic found;
        held  = '0;
        alloc = '0;
        found = 1'b0;
        for (int i = 0; i < int'(NUM_VOICES); i++) begin
            held[i] = active_q[i] && (key_q[i] == bus.scan_code);
            if (!active_q[i] && !found) begin
                alloc[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= StIdle;
        end else if (bus.scan_valid) begin
            case (state)
                StIdle: begin
                    if (bus.scan_code == SC_BREAK) state <= StBreak;
                    else if (bus.scan_code == SC_EXT) state <= StExt;
                end
                StBreak: begin
                    if (bus.scan_code == SC_BREAK) state <= StBreak;
                    else if (bus.scan_code == SC_EXT) state <= StExtBrk;
                    else state <= StIdle;
                end
                StExt: begin
                    if (bus.scan_code == SC_BREAK) state <= StExtBrk;
                    else if (bus.scan_code == SC_EXT) state <= StExt;
                    else state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= '0;
            drop_q   <= 1'b0;
            for (int i = 0; i < int'(NUM_VOICES); i++) begin
                key_q[i]  <= '0;
                note_q[i] <= '0;
            end
        end else begin
            drop_q <= 1'b0;
            if (make_ev && held == '0) begin
                if (alloc == '0) begin
                    drop_q <= 1'b1;
                end else begin
                    for (int i = 0; i < int'(NUM_VOICES); i++) begin
                        if (alloc[i]) begin
                            active_q[i] <= 1'b1;
                            key_q[i]    <= bus.scan_code;
                            note_q[i]   <= map_note;
                        end
                    end
                end
            end else if (break_ev) begin
                for (int i = 0; i < int'(NUM_VOICES); i++) begin
                    if (held[i]) begin
                        active_q[i] <= 1'b0;
                        key_q[i]    <= '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            octave_q <= '0;
        end else if (bus.oct_up && !bus.oct_dn && octave_q != OCT_W'(OCT_MAX)) begin
            octave_q <= octave_q + 1'b1;
        end else if (bus.oct_dn && !bus.oct_up && octave_q != '0) begin
            octave_q <= octave_q - 1'b1;
        end
    end

    // Output stage sees voice table and octave one edge after they change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_out_q <= '0;
            period_out_q <= '0;
        end else begin
            active_out_q <= active_q;
            for (int i = 0; i < int'(NUM_VOICES); i++) begin
                period_out_q[i*PERIOD_W +: PERIOD_W] <= active_q[i] ?
                    (PERIOD_W'(base_period(note_q[i])) >> octave_q) : '0;
            end
        end
    end

    assign bus.voice_active = active_out_q;
    assign bus.voice_period = period_out_q;
    assign bus.octave       = octave_q;
    assign bus.drop         = drop_q;

endmodule
